// File: rtl/sd_cmd_tx_pkg.sv
// Shared definitions for the SD command-line transmitter and its CRC7 helper.
package sd_cmd_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CRC,
    ST_ENDBIT,
    ST_GAP
  } state_e;

  localparam int unsigned FRAME_BITS   = 48;
  localparam int unsigned PAYLOAD_BITS = 40;

  // x^7 + x^3 + 1 with the x^7 term implicit.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Request and serial-line signals between a command issuer and sd_cmd_tx.
interface sd_cmd_tx_if;
  logic        StrobeEn;
  logic        Start;
  logic [5:0]  CmdIndex;
  logic [31:0] Arg;
  logic        Ready;
  logic        Done;
  logic        CmdOut;
  logic        CmdEn;

  modport master (
    output StrobeEn, Start, CmdIndex, Arg,
    input  Ready, Done, CmdOut, CmdEn
  );

  modport slave (
    input  StrobeEn, Start, CmdIndex, Arg,
    output Ready, Done, CmdOut, CmdEn
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per Enable; Clear wins over Enable.
module sd_crc7
  import sd_cmd_tx_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Enable,
  input  logic       DataIn,
  output logic [6:0] Crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = DataIn ^ crc_q[6];
    if (Clear) begin
      crc_d = '0;
    end else if (Enable) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign Crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command frame transmitter: 48-bit frame MSB first, one bit per StrobeEn,
// followed by GapBits idle strobes before accepting the next command.
module sd_cmd_tx
  import sd_cmd_tx_pkg::*;
#(
  parameter int unsigned GapBits = 8
) (
  input logic         Clk,
  input logic         Reset,
  sd_cmd_tx_if.slave  bus
);

  localparam int unsigned GapW = (GapBits > 1) ? $clog2(GapBits) : 1;

  state_e            state_q, state_d;
  logic [39:0]       sr_q, sr_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              cmd_out_q, cmd_out_d;
  logic              cmd_en_q, cmd_en_d;
  logic              done_q, done_d;
  logic              crc_clear, crc_en;
  logic [6:0]        crc;
  logic [5:0]        crc_pos;

  sd_crc7 u_crc7 (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (crc_clear),
    .Enable (crc_en),
    .DataIn (sr_q[39]),
    .Crc    (crc)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cmd_out_d = cmd_out_q;
    cmd_en_d  = cmd_en_q;
    done_d    = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    // bit_cnt runs 40..46 in ST_CRC, selecting CRC bits 6..0.
    crc_pos   = 6'(FRAME_BITS - 2) - bit_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          sr_d      = {START_BIT, TX_BIT, bus.CmdIndex, bus.Arg};
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          crc_clear = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.StrobeEn) begin
          cmd_out_d = sr_q[39];
          cmd_en_d  = 1'b1;
          sr_d      = {sr_q[38:0], 1'b0};
          crc_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(PAYLOAD_BITS - 1)) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        if (bus.StrobeEn) begin
          cmd_out_d = crc[crc_pos[2:0]];
          cmd_en_d  = 1'b1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(FRAME_BITS - 2)) state_d = ST_ENDBIT;
        end
      end
      ST_ENDBIT: begin
        // First strobe drives the end bit; the next one releases the line.
        if (bus.StrobeEn) begin
          if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
            cmd_out_d = END_BIT;
            cmd_en_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            cmd_out_d = 1'b1;
            cmd_en_d  = 1'b0;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (bus.StrobeEn) begin
          if (gap_cnt_q == GapW'(GapBits - 1)) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cmd_out_q <= 1'b1;
      cmd_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cmd_out_q <= cmd_out_d;
      cmd_en_q  <= cmd_en_d;
      done_q    <= done_d;
    end
  end

  assign bus.Ready  = (state_q == ST_IDLE);
  assign bus.Done   = done_q;
  assign bus.CmdOut = cmd_out_q;
  assign bus.CmdEn  = cmd_en_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: known command frames from a table, randomized frames
// against a polynomial-division CRC model, and abort/coincidence sequences.
module tb_sd_cmd_tx;

  localparam int unsigned GAP = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sd_cmd_tx_if bus_if ();

  sd_cmd_tx #(.GapBits(GAP)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int unsigned period;
    bit          coincide;
    bit          mid_start;
    logic [47:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    logic [46:0] rem;
    msg = {2'b01, idx, arg};
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem = rem ^ (47'(8'h89) << (i - 7));
    return {msg, rem[6:0], 1'b1};
  endfunction

  task automatic scramble();
    bus_if.CmdIndex = 6'($urandom);
    bus_if.Arg      = $urandom;
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                            input int unsigned period, input bit coincide,
                            input bit mid_start, input logic [47:0] exp,
                            input string tag);
    logic [47:0] got;
    bit hold_ok, en_ok, gap_ok;
    int unsigned waited;
    waited = 0;
    while (bus_if.Ready !== 1'b1 && waited < 500) begin
      tick();
      waited++;
    end
    check({tag, " ready_before"}, 64'(bus_if.Ready), 64'd1);
    bus_if.Start    = 1'b1;
    bus_if.CmdIndex = idx;
    bus_if.Arg      = arg;
    bus_if.StrobeEn = coincide;
    tick();
    bus_if.Start    = 1'b0;
    bus_if.StrobeEn = 1'b0;
    check({tag, " accept_ready"}, 64'(bus_if.Ready), 64'd0);
    check({tag, " accept_en"}, 64'(bus_if.CmdEn), 64'd0);
    hold_ok = 1'b1;
    en_ok   = 1'b1;
    got     = '0;
    for (int b = 0; b < 48; b++) begin
      for (int unsigned w = 1; w < period; w++) begin
        scramble();
        tick();
        if (bus_if.CmdEn !== (b != 0)) hold_ok = 1'b0;
        if (b != 0 && bus_if.CmdOut !== got[48 - b]) hold_ok = 1'b0;
      end
      scramble();
      if (mid_start && (b == 10 || b == 30)) bus_if.Start = 1'b1;
      bus_if.StrobeEn = 1'b1;
      tick();
      bus_if.StrobeEn = 1'b0;
      bus_if.Start    = 1'b0;
      got[47 - b] = bus_if.CmdOut;
      if (bus_if.CmdEn !== 1'b1 || bus_if.Done !== 1'b0 || bus_if.Ready !== 1'b0) en_ok = 1'b0;
    end
    check({tag, " frame"}, 64'(got), 64'(exp));
    check({tag, " drive_flags"}, 64'(en_ok), 64'd1);
    check({tag, " hold_between_strobes"}, 64'(hold_ok), 64'd1);
    for (int unsigned w = 1; w < period; w++) tick();
    bus_if.StrobeEn = 1'b1;
    tick();
    bus_if.StrobeEn = 1'b0;
    check({tag, " done_pulse"}, 64'(bus_if.Done), 64'd1);
    check({tag, " release_en"}, 64'(bus_if.CmdEn), 64'd0);
    check({tag, " release_out"}, 64'(bus_if.CmdOut), 64'd1);
    tick();
    check({tag, " done_single"}, 64'(bus_if.Done), 64'd0);
    gap_ok = 1'b1;
    for (int unsigned g = 0; g < GAP; g++) begin
      for (int unsigned w = 1; w < period; w++) tick();
      if (bus_if.Ready !== 1'b0 || bus_if.CmdEn !== 1'b0) gap_ok = 1'b0;
      bus_if.StrobeEn = 1'b1;
      tick();
      bus_if.StrobeEn = 1'b0;
    end
    check({tag, " gap_line_idle"}, 64'(gap_ok), 64'd1);
    check({tag, " ready_after_gap"}, 64'(bus_if.Ready), 64'd1);
  endtask

  initial begin
    vec_t vecs[5];
    logic [5:0]  ridx;
    logic [31:0] rarg;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.StrobeEn = 1'b0;
    bus_if.Start    = 1'b0;
    bus_if.CmdIndex = '0;
    bus_if.Arg      = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset ready", 64'(bus_if.Ready), 64'd1);
    check("reset done", 64'(bus_if.Done), 64'd0);
    check("reset cmd_en", 64'(bus_if.CmdEn), 64'd0);
    check("reset cmd_out", 64'(bus_if.CmdOut), 64'd1);

    vecs[0] = '{6'd0,  32'h0000_0000, 1, 1'b0, 1'b0, 48'h40_0000_0000_95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 2, 1'b0, 1'b0, 48'h48_0000_01AA_87};
    vecs[2] = '{6'd17, 32'h0000_0000, 1, 1'b0, 1'b0, 48'h51_0000_0000_55};
    vecs[3] = '{6'd17, 32'h0000_0000, 4, 1'b0, 1'b1, 48'h51_0000_0000_55};
    vecs[4] = '{6'd0,  32'h0000_0000, 3, 1'b1, 1'b0, 48'h40_0000_0000_95};
    for (int i = 0; i < 5; i++)
      send_frame(vecs[i].idx, vecs[i].arg, vecs[i].period, vecs[i].coincide,
                 vecs[i].mid_start, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset at bit 20, coincident with Start and StrobeEn.
    bus_if.Start = 1'b1;
    bus_if.CmdIndex = 6'd17;
    bus_if.Arg = 32'hDEAD_BEEF;
    tick();
    bus_if.Start = 1'b0;
    for (int b = 0; b < 20; b++) begin
      tick();
      bus_if.StrobeEn = 1'b1;
      tick();
      bus_if.StrobeEn = 1'b0;
    end
    check("pre_abort cmd_en", 64'(bus_if.CmdEn), 64'd1);
    rst = 1'b1;
    bus_if.Start = 1'b1;
    bus_if.StrobeEn = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.Start = 1'b0;
    bus_if.StrobeEn = 1'b0;
    check("abort cmd_en", 64'(bus_if.CmdEn), 64'd0);
    check("abort cmd_out", 64'(bus_if.CmdOut), 64'd1);
    check("abort ready", 64'(bus_if.Ready), 64'd1);
    check("abort done", 64'(bus_if.Done), 64'd0);
    tick();
    check("abort start_ignored", 64'(bus_if.Ready), 64'd1);
    send_frame(6'd0, 32'h0, 2, 1'b0, 1'b0, 48'h40_0000_0000_95, "post_abort");

    for (int r = 0; r < 6; r++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      send_frame(ridx, rarg, $urandom_range(1, 4), 1'($urandom), 1'($urandom),
                 model_frame(ridx, rarg), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
